// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, I-cache address, and a small
// {pc, instr} FIFO toward decode with redirect-driven flush.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] icache_addr,
    input  logic [31:0] icache_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [31:0]      r_pc;
    logic [31:0]      r_mem_pc    [DEPTH];
    logic [31:0]      r_mem_instr [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_out_valid;
    logic w_pop;
    logic w_push;

    // Decode handshake: a head entry transfers on any cycle where out_valid
    // and out_ready are both high; out_* come from FIFO state only, while
    // push may use out_ready combinationally to refill a full FIFO in place.
    assign w_out_valid = (r_count != '0);
    assign w_pop       = w_out_valid & out_ready;
    assign w_push      = ~redirect_valid & ((r_count != FULL_CNT) | w_pop);

    assign icache_addr = r_pc;
    assign out_valid   = w_out_valid;
    assign out_pc      = w_out_valid ? r_mem_pc[r_rd_ptr]    : 32'h0;
    assign out_instr   = w_out_valid ? r_mem_instr[r_rd_ptr] : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            // Flush discards everything, including an entry popped this cycle.
            r_pc     <= redirect_pc & ~32'h3;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_pc     <= r_pc + 32'd4;
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem_pc[r_wr_ptr]    <= r_pc;
            r_mem_instr[r_wr_ptr] <= icache_instr;
        end
    end
endmodule
